// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter:
// writeback modes, requester indices, address/data widths and
// the mode-to-half-select decode.
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [1:0] WB_MODE_FULL  = 2'b00;
  localparam logic [1:0] WB_MODE_LOW   = 2'b01;
  localparam logic [1:0] WB_MODE_UPPER = 2'b10;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_LI   = 2;

  // Returns {upper_sel, lower_sel}; mode 11 is treated as a full-word write,
  // so the two selects are never both set.
  function automatic logic [1:0] mode_to_sel(input logic [1:0] mode);
    logic [1:0] sel;
    case (mode)
      WB_MODE_LOW:   sel = 2'b01;
      WB_MODE_UPPER: sel = 2'b10;
      default:       sel = 2'b00;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the producers (execute/memory stages) and the
// arbiter: per-requester valid/ready handshake plus the register-file
// write-port controls driven back by the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3
);
  import regfile_wb_arbiter_pkg::*;

  logic [NUM_REQ-1:0]            req_valid_in;
  logic [REG_ADDR_W*NUM_REQ-1:0] req_rd_in;
  logic [DATA_W*NUM_REQ-1:0]     req_val_in;
  logic [2*NUM_REQ-1:0]          req_mode_in;
  logic [NUM_REQ-1:0]            req_ready_out;
  logic                          wb_out;
  logic [REG_ADDR_W-1:0]         rd_out;
  logic [DATA_W-1:0]             rd_val_out;
  logic                          wb_uh_out;
  logic                          wb_lh_out;

  modport master (
    output req_valid_in, req_rd_in, req_val_in, req_mode_in,
    input  req_ready_out, wb_out, rd_out, rd_val_out, wb_uh_out, wb_lh_out
  );

  modport slave (
    input  req_valid_in, req_rd_in, req_val_in, req_mode_in,
    output req_ready_out, wb_out, rd_out, rd_val_out, wb_uh_out, wb_lh_out
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// One-hot grant generator for the writeback port.
// Build option WB_ROUND_ROBIN_EN: rotating-pointer round robin;
// when undefined, fixed priority with the lowest index winning.
module wb_rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic [NUM_REQ-1:0] req_in,
  output logic [NUM_REQ-1:0] grant_out
);

`ifdef WB_ROUND_ROBIN_EN
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] gidx_s;
  logic             found_s;

  // Search from the pointer, wrapping, and take the first valid requester.
  always_comb begin
    int idx;
    grant_out = '0;
    gidx_s    = '0;
    found_s   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_r) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!found_s && req_in[idx]) begin
        grant_out[idx] = 1'b1;
        gidx_s         = idx[PTR_W-1:0];
        found_s        = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Advance the pointer past the winner; hold it when nobody was granted.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      ptr_r <= '0;
    end else if (found_s) begin
      if (gidx_s == PTR_W'(NUM_REQ - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= gidx_s + PTR_W'(1);
      end
    end
  end
`else
  logic found_s;
  logic unused_clk_rst_s;

  assign unused_clk_rst_s = clk_in ^ reset_in;

  // Fixed priority: the lowest-indexed valid requester wins.
  always_comb begin
    grant_out = '0;
    found_s   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && req_in[i]) begin
        grant_out[i] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: shares the single write port among
// NUM_REQ producers, registers the winning write, and tracks a
// pending-write scoreboard used by decode for operand stalls.
// Build option WB_ROUND_ROBIN_EN selects round-robin arbitration.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int REG_CNT = 32
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  regfile_wb_arbiter_if.slave   bus,
  input  logic                  issue_in,
  input  logic [REG_ADDR_W-1:0] issue_rd_in,
  input  logic [REG_ADDR_W-1:0] chk_a_in,
  input  logic [REG_ADDR_W-1:0] chk_b_in,
  output logic                  busy_a_out,
  output logic                  busy_b_out,
  output logic [REG_CNT-1:0]    pending_out
);

  logic [NUM_REQ-1:0]    arb_grant_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic                  any_grant_s;
  logic [REG_ADDR_W-1:0] sel_rd_s;
  logic [DATA_W-1:0]     sel_val_s;
  logic [1:0]            sel_mode_s;
  logic [REG_CNT-1:0]    pending_nxt_s;

  logic                  wb_r;
  logic [REG_ADDR_W-1:0] rd_r;
  logic [DATA_W-1:0]     val_r;
  logic                  uh_r;
  logic                  lh_r;
  logic [REG_CNT-1:0]    pending_r;

  wb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .req_in    (bus.req_valid_in),
    .grant_out (arb_grant_s)
  );

  // No grants are handed out while reset is asserted.
  assign grant_s     = arb_grant_s & {NUM_REQ{~reset_in}};
  assign any_grant_s = |grant_s;

  // Steer the granted requester's fields onto the write path.
  always_comb begin
    sel_rd_s   = '0;
    sel_val_s  = '0;
    sel_mode_s = WB_MODE_FULL;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        sel_rd_s   = bus.req_rd_in[REG_ADDR_W*i +: REG_ADDR_W];
        sel_val_s  = bus.req_val_in[DATA_W*i +: DATA_W];
        sel_mode_s = bus.req_mode_in[2*i +: 2];
      end else begin
        sel_rd_s = sel_rd_s;
      end
    end
  end

  // Next scoreboard: clear the written-back register, then set the issued
  // one so a same-cycle issue of a newer producer keeps the bit set.
  always_comb begin
    pending_nxt_s = pending_r;
    if (any_grant_s) begin
      pending_nxt_s[sel_rd_s] = 1'b0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (issue_in) begin
      pending_nxt_s[issue_rd_in] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
  end

  // Output stage: one-cycle registered write; address/data hold when idle.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wb_r  <= 1'b0;
      rd_r  <= '0;
      val_r <= '0;
      uh_r  <= 1'b0;
      lh_r  <= 1'b0;
    end else begin
      wb_r <= any_grant_s;
      if (any_grant_s) begin
        rd_r          <= sel_rd_s;
        val_r         <= sel_val_s;
        {uh_r, lh_r}  <= mode_to_sel(sel_mode_s);
      end else begin
        uh_r <= 1'b0;
        lh_r <= 1'b0;
      end
    end
  end

  // Scoreboard register of outstanding writes.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  assign bus.req_ready_out = grant_s;
  assign bus.wb_out        = wb_r;
  assign bus.rd_out        = rd_r;
  assign bus.rd_val_out    = val_r;
  assign bus.wb_uh_out     = uh_r;
  assign bus.wb_lh_out     = lh_r;

  assign busy_a_out  = pending_r[chk_a_in];
  assign busy_b_out  = pending_r[chk_b_in];
  assign pending_out = pending_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. Expectations follow the
// WB_ROUND_ROBIN_EN setting of the build.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int NUM_REQ = 3;

  logic        clk_in;
  logic        reset_in;
  logic        issue_in;
  logic [4:0]  issue_rd_in;
  logic [4:0]  chk_a_in;
  logic [4:0]  chk_b_in;
  logic        busy_a_out;
  logic        busy_b_out;
  logic [31:0] pending_out;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .REG_CNT(32)) dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .bus         (bus.slave),
    .issue_in    (issue_in),
    .issue_rd_in (issue_rd_in),
    .chk_a_in    (chk_a_in),
    .chk_b_in    (chk_b_in),
    .busy_a_out  (busy_a_out),
    .busy_b_out  (busy_b_out),
    .pending_out (pending_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] rd,
                         input logic [31:0] val, input logic [1:0] mode);
    bus.req_valid_in[i]      = v;
    bus.req_rd_in[5*i +: 5]  = rd;
    bus.req_val_in[32*i +: 32] = val;
    bus.req_mode_in[2*i +: 2] = mode;
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic [2:0] exp_g;
    reset_in         = 1'b1;
    bus.req_valid_in = '0;
    bus.req_rd_in    = '0;
    bus.req_val_in   = '0;
    bus.req_mode_in  = '0;
    issue_in         = 1'b0;
    issue_rd_in      = 5'd0;
    chk_a_in         = 5'd0;
    chk_b_in         = 5'd0;

    // Reset state
    tick();
    tick();
    chk("rst_wb", {31'd0, bus.wb_out}, 32'd0);
    chk("rst_rd", {27'd0, bus.rd_out}, 32'd0);
    chk("rst_val", bus.rd_val_out, 32'd0);
    chk("rst_pending", pending_out, 32'd0);
    reset_in = 1'b0;

    // Single ALU full-word write
    set_req(REQ_ALU, 1'b1, 5'd5, 32'hDEADBEEF, WB_MODE_FULL);
    #1;
    chk("single_ready", {29'd0, bus.req_ready_out}, 32'd1);
    tick();
    set_req(REQ_ALU, 1'b0, 5'd0, 32'd0, WB_MODE_FULL);
    chk("single_wb", {31'd0, bus.wb_out}, 32'd1);
    chk("single_rd", {27'd0, bus.rd_out}, 32'd5);
    chk("single_val", bus.rd_val_out, 32'hDEADBEEF);
    chk("single_uhlh", {30'd0, bus.wb_uh_out, bus.wb_lh_out}, 32'd0);
    tick();
    chk("idle_wb", {31'd0, bus.wb_out}, 32'd0);
    chk("idle_rd_hold", {27'd0, bus.rd_out}, 32'd5);
    chk("idle_val_hold", bus.rd_val_out, 32'hDEADBEEF);

    // LI half writes: upper then lower, then LOAD with mode 11
    set_req(REQ_LI, 1'b1, 5'd7, 32'h00001234, WB_MODE_UPPER);
    #1;
    chk("half_ready", {29'd0, bus.req_ready_out}, 32'd4);
    tick();
    set_req(REQ_LI, 1'b1, 5'd7, 32'h0000ABCD, WB_MODE_LOW);
    chk("upper_uhlh", {30'd0, bus.wb_uh_out, bus.wb_lh_out}, 32'd2);
    chk("upper_val", {16'd0, bus.rd_val_out[15:0]}, 32'h1234);
    chk("upper_rd", {27'd0, bus.rd_out}, 32'd7);
    tick();
    set_req(REQ_LI, 1'b0, 5'd0, 32'd0, WB_MODE_FULL);
    set_req(REQ_LOAD, 1'b1, 5'd12, 32'hCAFE0001, 2'b11);
    chk("lower_uhlh", {30'd0, bus.wb_uh_out, bus.wb_lh_out}, 32'd1);
    chk("lower_val", {16'd0, bus.rd_val_out[15:0]}, 32'hABCD);
    tick();
    set_req(REQ_LOAD, 1'b0, 5'd0, 32'd0, WB_MODE_FULL);
    chk("mode11_uhlh", {30'd0, bus.wb_uh_out, bus.wb_lh_out}, 32'd0);
    chk("mode11_rd", {27'd0, bus.rd_out}, 32'd12);
    // Round-robin pointer now sits at 2 (last grant was LOAD).
    tick();

    // Bring the pointer back to 0 with one LI grant.
    set_req(REQ_LI, 1'b1, 5'd20, 32'd20, WB_MODE_FULL);
    tick();
    set_req(REQ_LI, 1'b0, 5'd0, 32'd0, WB_MODE_FULL);
    tick();

    // All three requesters held valid for six cycles
    set_req(REQ_ALU, 1'b1, 5'd1, 32'h101, WB_MODE_FULL);
    set_req(REQ_LOAD, 1'b1, 5'd2, 32'h102, WB_MODE_FULL);
    set_req(REQ_LI, 1'b1, 5'd3, 32'h103, WB_MODE_FULL);
    for (int k = 0; k < 6; k++) begin
`ifdef WB_ROUND_ROBIN_EN
      exp_g = 3'b001 << (k % 3);
`else
      exp_g = 3'b001;
`endif
      #1;
      chk($sformatf("contend_ready_%0d", k), {29'd0, bus.req_ready_out}, {29'd0, exp_g});
      tick();
      chk($sformatf("contend_rd_%0d", k), {27'd0, bus.rd_out},
          (exp_g == 3'b001) ? 32'd1 : (exp_g == 3'b010) ? 32'd2 : 32'd3);
    end
    bus.req_valid_in = '0;
    tick();
    tick();

    // Scoreboard set and clear
    issue_in    = 1'b1;
    issue_rd_in = 5'd9;
    chk_a_in    = 5'd9;
    chk_b_in    = 5'd9;
    #1;
    chk("sb_no_bypass", {31'd0, busy_a_out}, 32'd0);
    tick();
    issue_in = 1'b0;
    chk("sb_busy_a", {31'd0, busy_a_out}, 32'd1);
    chk("sb_busy_b", {31'd0, busy_b_out}, 32'd1);
    chk("sb_vec", pending_out, 32'h0000_0200);
    set_req(REQ_ALU, 1'b1, 5'd9, 32'h99, WB_MODE_FULL);
    #1;
    chk("sb_busy_at_grant", {31'd0, busy_a_out}, 32'd1);
    tick();
    set_req(REQ_ALU, 1'b0, 5'd0, 32'd0, WB_MODE_FULL);
    chk("sb_cleared", {31'd0, busy_a_out}, 32'd0);

    // Collision: issue and grant on rd=3 in the same cycle
    issue_in    = 1'b1;
    issue_rd_in = 5'd3;
    set_req(REQ_ALU, 1'b1, 5'd3, 32'h33, WB_MODE_FULL);
    tick();
    issue_in = 1'b0;
    chk("collide_set_wins", pending_out, 32'h0000_0008);
    // Clear rd=3, then clearing an unset rd=4 is harmless.
    tick();
    chk("collide_clear", pending_out, 32'd0);
    set_req(REQ_ALU, 1'b1, 5'd4, 32'h44, WB_MODE_FULL);
    tick();
    set_req(REQ_ALU, 1'b0, 5'd0, 32'd0, WB_MODE_FULL);
    chk("clear_unset", pending_out, 32'd0);
    tick();

    // Reset with a write latched in the output stage
    issue_in    = 1'b1;
    issue_rd_in = 5'd10;
    set_req(REQ_LOAD, 1'b1, 5'd11, 32'h55, WB_MODE_FULL);
    tick();
    issue_in = 1'b0;
    set_req(REQ_LOAD, 1'b0, 5'd0, 32'd0, WB_MODE_FULL);
    chk("pre_rst_wb", {31'd0, bus.wb_out}, 32'd1);
    chk("pre_rst_pending", pending_out, 32'h0000_0400);
    reset_in = 1'b1;
    set_req(REQ_LI, 1'b1, 5'd13, 32'h77, WB_MODE_FULL);
    #1;
    chk("rst_ready", {29'd0, bus.req_ready_out}, 32'd0);
    tick();
    chk("mid_rst_wb", {31'd0, bus.wb_out}, 32'd0);
    chk("mid_rst_pending", pending_out, 32'd0);
    reset_in = 1'b0;
    set_req(REQ_ALU, 1'b1, 5'd14, 32'h88, WB_MODE_FULL);
    set_req(REQ_LOAD, 1'b1, 5'd15, 32'h99, WB_MODE_FULL);
    #1;
    chk("post_rst_ready0", {29'd0, bus.req_ready_out}, 32'd1);
    tick();
    chk("post_rst_rd", {27'd0, bus.rd_out}, 32'd14);
`ifdef WB_ROUND_ROBIN_EN
    exp_g = 3'b010;
`else
    exp_g = 3'b001;
`endif
    #1;
    chk("post_rst_ready1", {29'd0, bus.req_ready_out}, {29'd0, exp_g});
    bus.req_valid_in = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
